alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker_if.sv | 35 +++
 rtl/alu_result_checker.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_checker_if.sv
// Stimulus/observation bundle for alu_result_checker: the vector being
// driven to the ALU under test, the ALU's answer, and the session tallies.
interface alu_result_checker_if;
  logic        start;
  logic        stop;
  logic        valid;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [2:0]  select;
  logic [7:0]  result;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic [15:0] skip_count;
  logic [15:0] fail_index;
  logic [2:0]  fail_select;
  logic [7:0]  fail_expected;
  logic [7:0]  fail_result;

  // Stimulus side: drives vectors and session control, reads the tallies.
  modport master (
    output start, stop, valid, data1, data2, select, result,
    input  busy, done, error, pass_count, fail_count, skip_count,
           fail_index, fail_select, fail_expected, fail_result
  );

  // Checker side.
  modport slave (
    input  start, stop, valid, data1, data2, select, result,
    output busy, done, error, pass_count, fail_count, skip_count,
           fail_index, fail_select, fail_expected, fail_result
  );
endinterface

// File: rtl/alu_result_checker.sv
// Online checker for a small ALU. Each accepted vector has its expected
// value computed from the operands, is delayed by LATENCY cycles to line up
// with the ALU's RESULT, and is then scored as pass, fail or skip (reserved
// opcode). The first mismatch of a session is captured for debug.
// LATENCY must lie in 0..4.
module alu_result_checker #(
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_checker_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               busy_r;
  logic               done_r;

  logic               clr;
  logic               accept;
  logic               inflight;
  logic [DATA_W-1:0]  acc_exp;

  logic               cmp_vld;
  logic [DATA_W-1:0]  cmp_exp;
  logic [2:0]         cmp_sel;
  logic [CNT_W-1:0]   cmp_idx;

  logic [CNT_W-1:0]   vec_idx;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic [CNT_W-1:0]   skip_cnt;
  logic               error_r;
  logic [CNT_W-1:0]   fail_idx_r;
  logic [2:0]         fail_sel_r;
  logic [DATA_W-1:0]  fail_exp_r;
  logic [DATA_W-1:0]  fail_res_r;

  // Golden ALU behaviour; reserved opcodes return 0 and are never scored.
  function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [2:0]        sel);
    case (sel)
      3'd0:    return b;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return '0;
    endcase
  endfunction

  // Counters and the vector index stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // START is only honoured from IDLE/DONE; it wins over a coincident STOP.
  assign clr     = ((state == IDLE) || (state == DONE)) && bus.start;
  assign accept  = (state == RUN) && bus.valid;
  assign acc_exp = alu_ref(bus.data1, bus.data2, bus.select);

  // Session FSM with registered BUSY/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // inflight means something is still queued behind the vector
          // (if any) being resolved at this edge.
          if (!inflight) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (LATENCY == 0) begin : g_direct
      // Score the vector in the very cycle it is accepted.
      assign cmp_vld  = accept;
      assign cmp_exp  = acc_exp;
      assign cmp_sel  = bus.select;
      assign cmp_idx  = vec_idx;
      assign inflight = 1'b0;
    end else begin : g_pipe
      logic              vld_p [LATENCY];
      logic [DATA_W-1:0] exp_p [LATENCY];
      logic [2:0]        sel_p [LATENCY];
      logic [CNT_W-1:0]  idx_p [LATENCY];

      // Valid-tagged delay line carrying expected value, opcode and index.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            vld_p[i] <= 1'b0;
            exp_p[i] <= '0;
            sel_p[i] <= '0;
            idx_p[i] <= '0;
          end
        end else if (clr) begin
          for (int i = 0; i < LATENCY; i++) begin
            vld_p[i] <= 1'b0;
            exp_p[i] <= '0;
            sel_p[i] <= '0;
            idx_p[i] <= '0;
          end
        end else begin
          vld_p[0] <= accept;
          exp_p[0] <= acc_exp;
          sel_p[0] <= bus.select;
          idx_p[0] <= vec_idx;
          for (int i = 1; i < LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
            exp_p[i] <= exp_p[i-1];
            sel_p[i] <= sel_p[i-1];
            idx_p[i] <= idx_p[i-1];
          end
        end
      end

      // Any vector that will still be queued after this edge.
      always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
          inflight = inflight | vld_p[i];
        end
      end

      assign cmp_vld = vld_p[LATENCY-1];
      assign cmp_exp = exp_p[LATENCY-1];
      assign cmp_sel = sel_p[LATENCY-1];
      assign cmp_idx = idx_p[LATENCY-1];
    end
  endgenerate

  // Index handed to the next accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx <= '0;
    end else if (clr) begin
      vec_idx <= '0;
    end else if (accept) begin
      vec_idx <= sat_inc(vec_idx);
    end
  end

  // Scoring of the vector at the compare point, plus first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      skip_cnt   <= '0;
      error_r    <= 1'b0;
      fail_idx_r <= '0;
      fail_sel_r <= '0;
      fail_exp_r <= '0;
      fail_res_r <= '0;
    end else if (clr) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      skip_cnt   <= '0;
      error_r    <= 1'b0;
      fail_idx_r <= '0;
      fail_sel_r <= '0;
      fail_exp_r <= '0;
      fail_res_r <= '0;
    end else if (cmp_vld) begin
      if (cmp_sel[2]) begin
        skip_cnt <= sat_inc(skip_cnt);
      end else if (bus.result == cmp_exp) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
        error_r  <= 1'b1;
        if (!error_r) begin
          fail_idx_r <= cmp_idx;
          fail_sel_r <= cmp_sel;
          fail_exp_r <= cmp_exp;
          fail_res_r <= bus.result;
        end
      end
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.error         = error_r;
  assign bus.pass_count    = pass_cnt;
  assign bus.fail_count    = fail_cnt;
  assign bus.skip_count    = skip_cnt;
  assign bus.fail_index    = fail_idx_r;
  assign bus.fail_select   = fail_sel_r;
  assign bus.fail_expected = fail_exp_r;
  assign bus.fail_result   = fail_res_r;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker (LATENCY=1): directed cases plus randomized
// sessions scored against a vector-level model of the checking rules.
module tb_alu_result_checker;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_result_checker_if bus ();

  alu_result_checker #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    logic [7:0] res;
  } vec_t;

  vec_t vq[$];

  // Model of the session tallies.
  int m_pass, m_fail, m_skip, m_idx;
  bit m_err;
  int m_fidx, m_fsel, m_fexp, m_fres;

  // Expected ALU output, or -1 for a reserved opcode.
  function automatic int model_expect(input int a, input int b, input int s);
    case (s)
      0:       return b;
      1:       return (a + b) % 256;
      2:       return a & b;
      3:       return a | b;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_skip = 0; m_idx = 0; m_err = 1'b0;
    m_fidx = 0; m_fsel = 0; m_fexp = 0; m_fres = 0;
  endtask

  task automatic model_accept(input vec_t v);
    int e;
    e = model_expect(int'(v.d1), int'(v.d2), int'(v.sel));
    if (e < 0) begin
      if (m_skip < 65535) m_skip++;
    end else if (int'(v.res) == e) begin
      if (m_pass < 65535) m_pass++;
    end else begin
      if (m_fail < 65535) m_fail++;
      if (!m_err) begin
        m_err = 1'b1;
        m_fidx = m_idx; m_fsel = int'(v.sel); m_fexp = e; m_fres = int'(v.res);
      end
    end
    if (m_idx < 65535) m_idx++;
  endtask

  function automatic vec_t mk_vec(input logic [7:0] d1, input logic [7:0] d2,
                                  input logic [2:0] sel, input logic [7:0] res);
    vec_t v;
    v.d1 = d1; v.d2 = d2; v.sel = sel; v.res = res;
    return v;
  endfunction

  function automatic vec_t rand_vec(input int bad_pct);
    vec_t v;
    int e;
    v.d1  = 8'($urandom);
    v.d2  = 8'($urandom);
    v.sel = 3'($urandom_range(5, 0));
    e = model_expect(int'(v.d1), int'(v.d2), int'(v.sel));
    if (e < 0)
      v.res = 8'($urandom);
    else if (int'($urandom_range(99, 0)) < bad_pct)
      v.res = 8'(e) ^ (8'd1 << $urandom_range(7, 0));
    else
      v.res = 8'(e);
    return v;
  endfunction

  // One clock of stimulus: inputs set just after an edge, sampled at the next.
  task automatic drive(input logic s, input logic p, input logic v,
                       input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] sel, input logic [7:0] res);
    bus.start = s; bus.stop = p; bus.valid = v;
    bus.data1 = d1; bus.data2 = d2; bus.select = sel; bus.result = res;
    @(posedge clk);
    #1;
  endtask

  // START, the queued vectors (RESULT trails its vector by one cycle), STOP.
  task automatic play_session(input bit stop_last, input bit noise);
    logic [7:0] pend;
    int n;
    vec_t v;
    n = vq.size();
    pend = 8'h00;
    model_clear();
    drive(1'b1, 1'b0, noise, 8'($urandom), 8'($urandom), 3'($urandom), pend);
    for (int i = 0; i < n; i++) begin
      v = vq[i];
      drive(1'b0, stop_last && (i == n - 1), 1'b1, v.d1, v.d2, v.sel, pend);
      model_accept(v);
      pend = v.res;
    end
    if (stop_last && n > 0)
      drive(1'b0, 1'b0, noise, 8'($urandom), 8'($urandom), 3'($urandom), pend);
    else
      drive(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom), pend);
    vq.delete();
  endtask

  task automatic wait_done(input bit noise);
    for (int i = 0; i < 8 && bus.done !== 1'b1; i++)
      drive(1'b0, 1'b0, noise, 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom));
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.valid = 1'b0;
    bus.data1 = '0; bus.data2 = '0; bus.select = '0; bus.result = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.error});
    end
    checks++;
    if ((bus.pass_count | bus.fail_count | bus.skip_count | bus.fail_index) !== 16'h0) begin
      errors++; $display("FAIL reset_counts: got p%0h f%0h s%0h i%0h want 0",
                         bus.pass_count, bus.fail_count, bus.skip_count, bus.fail_index);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // STOP and VALID in IDLE must not start anything.
    repeat (3) drive(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 3'd1, 8'h46);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL idle_hold: got busy/done %b want 00", {bus.busy, bus.done});
    end
    checks++;
    if (bus.pass_count !== 16'h0) begin
      errors++; $display("FAIL idle_no_count: got %0h want 0", bus.pass_count);
    end
  endtask

  task automatic test_directed_pass();
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd0, 8'h26));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd1, 8'h42));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd2, 8'h04));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd3, 8'h3E));
    play_session(1'b0, 1'b0);
    wait_done(1'b0);
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      errors++; $display("FAIL pass4_done: got busy/done %b want 01", {bus.busy, bus.done});
    end
    checks++;
    if (bus.pass_count !== 16'd4) begin
      errors++; $display("FAIL pass4_pass: got %0d want 4", bus.pass_count);
    end
    checks++;
    if (bus.fail_count !== 16'd0 || bus.error !== 1'b0) begin
      errors++; $display("FAIL pass4_fail: got fail %0d err %b want 0 0", bus.fail_count, bus.error);
    end
  endtask

  task automatic test_first_fail();
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd0, 8'h26));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd0, 8'h26));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd1, 8'h41));
    vq.push_back(mk_vec(8'h1C, 8'h26, 3'd3, 8'h00));
    play_session(1'b0, 1'b0);
    wait_done(1'b0);
    checks++;
    if (bus.fail_count !== 16'd2 || bus.error !== 1'b1 || bus.pass_count !== 16'd2) begin
      errors++; $display("FAIL ff_counts: got fail %0d err %b pass %0d want 2 1 2",
                         bus.fail_count, bus.error, bus.pass_count);
    end
    checks++;
    if (bus.fail_index !== 16'd2 || bus.fail_select !== 3'd1) begin
      errors++; $display("FAIL ff_where: got idx %0d sel %0d want 2 1", bus.fail_index, bus.fail_select);
    end
    checks++;
    if (bus.fail_expected !== 8'h42 || bus.fail_result !== 8'h41) begin
      errors++; $display("FAIL ff_values: got exp %0h res %0h want 42 41",
                         bus.fail_expected, bus.fail_result);
    end
  endtask

  task automatic test_boundary();
    vq.push_back(mk_vec(8'hFF, 8'h01, 3'd1, 8'h00));
    vq.push_back(mk_vec(8'h5A, 8'hA5, 3'd5, 8'($urandom)));
    play_session(1'b1, 1'b0);
    wait_done(1'b0);
    checks++;
    if (bus.pass_count !== 16'd1 || bus.skip_count !== 16'd1 || bus.fail_count !== 16'd0) begin
      errors++; $display("FAIL carry_skip: got p%0d s%0d f%0d want p1 s1 f0",
                         bus.pass_count, bus.skip_count, bus.fail_count);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
      errors++; $display("FAIL carry_skip_flags: got done %b err %b want 1 0", bus.done, bus.error);
    end
  endtask

  task automatic test_valid_outside();
    repeat (3) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 3'd1, 8'($urandom));
    repeat (6) vq.push_back(rand_vec(30));
    play_session(1'b1, 1'b1);
    wait_done(1'b1);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL vo_done: got %b want 1", bus.done);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 3'd0, 8'($urandom));
    checks++;
    if (bus.pass_count !== 16'(m_pass) || bus.fail_count !== 16'(m_fail) ||
        bus.skip_count !== 16'(m_skip)) begin
      errors++; $display("FAIL vo_counts: got p%0d f%0d s%0d want p%0d f%0d s%0d",
                         bus.pass_count, bus.fail_count, bus.skip_count, m_pass, m_fail, m_skip);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      repeat ($urandom_range(40, 5)) vq.push_back(rand_vec(25));
      play_session(s[0], s[1]);
      wait_done(s[1]);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_done: got busy/done %b want 01", s, {bus.busy, bus.done});
      end
      checks++;
      if (bus.pass_count !== 16'(m_pass) || bus.fail_count !== 16'(m_fail) ||
          bus.skip_count !== 16'(m_skip) || bus.error !== m_err) begin
        errors++; $display("FAIL rnd%0d_counts: got p%0d f%0d s%0d e%b want p%0d f%0d s%0d e%b", s,
                           bus.pass_count, bus.fail_count, bus.skip_count, bus.error,
                           m_pass, m_fail, m_skip, m_err);
      end
      checks++;
      if (bus.fail_index !== 16'(m_fidx) || bus.fail_select !== 3'(m_fsel) ||
          bus.fail_expected !== 8'(m_fexp) || bus.fail_result !== 8'(m_fres)) begin
        errors++; $display("FAIL rnd%0d_capture: got i%0d s%0d e%0h r%0h want i%0d s%0d e%0h r%0h", s,
                           bus.fail_index, bus.fail_select, bus.fail_expected, bus.fail_result,
                           m_fidx, m_fsel, m_fexp, m_fres);
      end
    end
  endtask

  task automatic test_start_priority();
    // START together with STOP from DONE starts a fresh session.
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
    checks++;
    if ({bus.busy, bus.done} !== 2'b10 || bus.pass_count !== 16'd0) begin
      errors++; $display("FAIL prio_start: got busy/done %b pass %0d want 10 0",
                         {bus.busy, bus.done}, bus.pass_count);
    end
    // START inside RUN is ignored; the vector alongside it still counts.
    drive(1'b1, 1'b0, 1'b1, 8'hF0, 8'h3C, 3'd2, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0, 3'd3, 8'h30);
    checks++;
    if (bus.busy !== 1'b1 || bus.pass_count !== 16'd1) begin
      errors++; $display("FAIL prio_run_start: got busy %b pass %0d want 1 1", bus.busy, bus.pass_count);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 8'hEE);
    wait_done(1'b0);
    checks++;
    if (bus.pass_count !== 16'd1 || bus.fail_count !== 16'd1 || bus.fail_index !== 16'd1 ||
        bus.fail_expected !== 8'hFF || bus.fail_result !== 8'hEE) begin
      errors++; $display("FAIL prio_result: got p%0d f%0d i%0d e%0h r%0h want p1 f1 i1 eff ree",
                         bus.pass_count, bus.fail_count, bus.fail_index,
                         bus.fail_expected, bus.fail_result);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 3'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 3'd1, 8'h20);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 3'd2, 8'h31);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 3'd3, 8'h00);
    checks++;
    if (bus.error !== 1'b1 || bus.pass_count !== 16'd2 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got err %b pass %0d busy %b want 1 2 1",
                         bus.error, bus.pass_count, bus.busy);
    end
    bus.result = 8'h30;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.error} !== 3'b000 ||
        (bus.pass_count | bus.fail_count | bus.skip_count | bus.fail_index) !== 16'h0 ||
        bus.fail_select !== 3'd0 || (bus.fail_expected | bus.fail_result) !== 8'h0) begin
      errors++; $display("FAIL ar_async: got flags %b p%0d f%0d i%0d e%0h r%0h want all 0",
                         {bus.busy, bus.done, bus.error}, bus.pass_count, bus.fail_count,
                         bus.fail_index, bus.fail_expected, bus.fail_result);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h10, 8'h20, 3'd3, 8'h30);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.pass_count !== 16'd0 || bus.fail_count !== 16'd0) begin
      errors++; $display("FAIL ar_late: got busy/done %b pass %0d fail %0d want 00 0 0",
                         {bus.busy, bus.done}, bus.pass_count, bus.fail_count);
    end
  endtask

  task automatic test_saturation();
    vec_t v;
    for (int i = 0; i < 70000; i++) begin
      v = rand_vec(0);
      if (v.sel[2]) v.sel = 3'd1;
      v.res = 8'(model_expect(int'(v.d1), int'(v.d2), int'(v.sel)));
      if (i == 69999) v.res = ~v.res;
      vq.push_back(v);
    end
    play_session(1'b1, 1'b0);
    wait_done(1'b0);
    checks++;
    if (bus.pass_count !== 16'(m_pass) || bus.pass_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_pass: got %0h want %0h", bus.pass_count, m_pass);
    end
    checks++;
    if (bus.fail_count !== 16'd1 || bus.fail_index !== 16'(m_fidx)) begin
      errors++; $display("FAIL sat_index: got fail %0d idx %0h want 1 %0h",
                         bus.fail_count, bus.fail_index, m_fidx);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
    checks++;
    if (bus.pass_count !== 16'd0 || bus.fail_count !== 16'd0 || bus.error !== 1'b0 ||
        bus.fail_index !== 16'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL sat_restart: got p%0h f%0h e%b i%0h busy %b want 0 0 0 0 1",
                         bus.pass_count, bus.fail_count, bus.error, bus.fail_index, bus.busy);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
    wait_done(1'b0);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL sat_empty_drain: got done %b want 1", bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_directed_pass();
    test_first_fail();
    test_boundary();
    test_valid_outside();
    test_random();
    test_start_priority();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
